// File: rtl/hash_table_pkg.sv
// Shared types for the linear-probing hash table.
package hash_table_pkg;

    typedef enum logic [1:0] {
        INSERT = 2'b00,
        DELETE = 2'b01,
        SEARCH = 2'b10,
        RSVD   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        EMPTY     = 2'b00,
        VALID     = 2'b01,
        TOMBSTONE = 2'b10
    } slot_state_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        PROBE = 2'b01,
        DONE  = 2'b10
    } fsm_state_e;

    typedef enum logic [1:0] {
        NONE      = 2'b00,
        FULL      = 2'b01,
        NOT_FOUND = 2'b10,
        BAD_OP    = 2'b11
    } err_e;

endpackage

// File: rtl/hash_index_gen.sv
// Key to home-slot index: key mod TOTAL_ENTRY or XOR fold of index-wide chunks.
module hash_index_gen #(
    parameter int KEY_WIDTH      = 32,
    parameter int TOTAL_ENTRY    = 64,
    parameter     HASH_ALGORITHM = "MODULUS",
    localparam int INDEX_WIDTH   = $clog2(TOTAL_ENTRY)
) (
    input  logic [KEY_WIDTH-1:0]   key,
    output logic [INDEX_WIDTH-1:0] index
);

    localparam int NCHUNK = (KEY_WIDTH + INDEX_WIDTH - 1) / INDEX_WIDTH;
    localparam int PW     = NCHUNK * INDEX_WIDTH;

    generate
        if (HASH_ALGORITHM == "XOR_FOLD") begin : g_xor
            logic [PW-1:0] padded;
            assign padded = PW'(key);
            always_comb begin
                index = '0;
                for (int c = 0; c < NCHUNK; c++) begin
                    index = index ^ padded[c*INDEX_WIDTH +: INDEX_WIDTH];
                end
            end
        end else begin : g_mod
            logic unused_bits;
            assign unused_bits = ^key[KEY_WIDTH-1:INDEX_WIDTH];
            assign index = key[INDEX_WIDTH-1:0];
        end
    endgenerate

endmodule

// File: rtl/hash_table_lp.sv
// Open-addressing hash table, linear probing, one slot examined per cycle.
// Define HASH_TABLE_STATS_EN to add occupancy/tombstone_count outputs.
module hash_table_lp
    import hash_table_pkg::*;
#(
    parameter int KEY_WIDTH      = 32,
    parameter int VALUE_WIDTH    = 32,
    parameter int TOTAL_ENTRY    = 64,
    parameter int MAX_PROBE      = 8,
    parameter     HASH_ALGORITHM = "MODULUS",
    localparam int IW            = $clog2(TOTAL_ENTRY),
    localparam int PW            = $clog2(MAX_PROBE + 1),
    localparam int CW            = $clog2(TOTAL_ENTRY + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [KEY_WIDTH-1:0]   key_in,
    input  logic [VALUE_WIDTH-1:0] value_in,
    input  logic [1:0]             op_sel,
    input  logic                   op_en,
    output logic                   op_ready,
    output logic [VALUE_WIDTH-1:0] value_out,
    output logic                   op_done,
    output logic                   op_error,
    output logic [1:0]             error_code,
`ifdef HASH_TABLE_STATS_EN
    output logic [CW-1:0]          occupancy,
    output logic [CW-1:0]          tombstone_count,
`endif
    output logic [PW-1:0]          probe_count
);

    fsm_state_e             state;
    op_e                    lop;
    logic [KEY_WIDTH-1:0]   lkey;
    logic [VALUE_WIDTH-1:0] lval;
    logic [IW-1:0]          ptr;
    logic [IW-1:0]          home;
    logic [PW-1:0]          pidx;
    logic                   free_vld;
    logic [IW-1:0]          free_idx;

    slot_state_e            slot_st [TOTAL_ENTRY];
    logic [KEY_WIDTH-1:0]   keys    [TOTAL_ENTRY];
    logic [VALUE_WIDTH-1:0] vals    [TOTAL_ENTRY];

    slot_state_e   cur_st;
    logic          hit;
    logic          last;
    logic          fin;
    err_e          fin_err;
    logic [PW-1:0] fin_pc;
    logic          wr_new;
    logic [IW-1:0] wr_idx;
    logic          upd;
    logic          tomb;
    logic          load;

    hash_index_gen #(
        .KEY_WIDTH      (KEY_WIDTH),
        .TOTAL_ENTRY    (TOTAL_ENTRY),
        .HASH_ALGORITHM (HASH_ALGORITHM)
    ) u_hash (
        .key   (key_in),
        .index (home)
    );

    assign op_ready = (state == IDLE);
    assign cur_st   = slot_st[ptr];
    assign hit      = (cur_st == VALID) && (keys[ptr] == lkey);
    assign last     = (pidx == PW'(MAX_PROBE - 1));

    always_comb begin
        fin     = 1'b0;
        fin_err = NONE;
        fin_pc  = pidx;
        wr_new  = 1'b0;
        wr_idx  = ptr;
        upd     = 1'b0;
        tomb    = 1'b0;
        load    = 1'b0;
        if (lop == INSERT) begin
            if (hit) begin
                fin = 1'b1;
                upd = 1'b1;
            end else if (cur_st == EMPTY) begin
                fin    = 1'b1;
                wr_new = 1'b1;
                wr_idx = free_vld ? free_idx : ptr;
            end else if (last) begin
                fin    = 1'b1;
                fin_pc = PW'(MAX_PROBE);
                // Free slot may be the one under the pointer right now.
                if (free_vld || cur_st == TOMBSTONE) begin
                    wr_new = 1'b1;
                    wr_idx = free_vld ? free_idx : ptr;
                end else begin
                    fin_err = FULL;
                end
            end
        end else begin
            if (hit) begin
                fin  = 1'b1;
                tomb = (lop == DELETE);
                load = (lop == SEARCH);
            end else if (cur_st == EMPTY) begin
                fin     = 1'b1;
                fin_err = NOT_FOUND;
            end else if (last) begin
                fin     = 1'b1;
                fin_err = NOT_FOUND;
                fin_pc  = PW'(MAX_PROBE);
            end
        end
    end

    // Request latch, probe walk and key/value storage carry no reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && op_en) begin
            lkey     <= key_in;
            lval     <= value_in;
            lop      <= op_e'(op_sel);
            ptr      <= home;
            pidx     <= '0;
            free_vld <= 1'b0;
            free_idx <= '0;
        end else if (state == PROBE) begin
            if (upd) begin
                vals[ptr] <= lval;
            end
            if (wr_new) begin
                keys[wr_idx] <= lkey;
                vals[wr_idx] <= lval;
            end
            if (!fin) begin
                ptr  <= ptr + 1'b1;
                pidx <= pidx + 1'b1;
                if (!free_vld && cur_st == TOMBSTONE) begin
                    free_vld <= 1'b1;
                    free_idx <= ptr;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            op_done     <= 1'b0;
            op_error    <= 1'b0;
            error_code  <= 2'b00;
            probe_count <= '0;
            value_out   <= '0;
            for (int i = 0; i < TOTAL_ENTRY; i++) begin
                slot_st[i] <= EMPTY;
            end
`ifdef HASH_TABLE_STATS_EN
            occupancy       <= '0;
            tombstone_count <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    op_done <= 1'b0;
                    if (op_en) begin
                        if (op_e'(op_sel) == RSVD) begin
                            state       <= DONE;
                            op_done     <= 1'b1;
                            op_error    <= 1'b1;
                            error_code  <= BAD_OP;
                            probe_count <= '0;
                        end else begin
                            state <= PROBE;
                        end
                    end
                end
                PROBE: begin
                    if (fin) begin
                        state       <= DONE;
                        op_done     <= 1'b1;
                        op_error    <= (fin_err != NONE);
                        error_code  <= fin_err;
                        probe_count <= fin_pc;
                        if (load) begin
                            value_out <= vals[ptr];
                        end
                        if (tomb) begin
                            slot_st[ptr] <= TOMBSTONE;
                        end
                        if (wr_new) begin
                            slot_st[wr_idx] <= VALID;
                        end
`ifdef HASH_TABLE_STATS_EN
                        if (wr_new) begin
                            occupancy <= occupancy + 1'b1;
                            if (slot_st[wr_idx] == TOMBSTONE) begin
                                tombstone_count <= tombstone_count - 1'b1;
                            end
                        end
                        if (tomb) begin
                            occupancy       <= occupancy - 1'b1;
                            tombstone_count <= tombstone_count + 1'b1;
                        end
`endif
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    op_done <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    op_done <= 1'b0;
                end
            endcase
        end
    end

endmodule
